// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared widths, FSM state codes and HALT decode for the program loader.
package program_loader_pkg;
  localparam int NB_BYTE        = 8;
  localparam int NB_INSTRUCTION = 2 * NB_BYTE;
  localparam int NB_OPCODE      = 5;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_ERROR     = 3'd4;
  localparam logic [NB_OPCODE-1:0] OPCODE_HALT = 5'b00000;
  typedef logic [NB_BYTE-1:0]        byte_t;
  typedef logic [NB_INSTRUCTION-1:0] instr_t;
  function automatic logic is_halt(input instr_t i);
    return i[NB_INSTRUCTION-1 -: NB_OPCODE] == OPCODE_HALT;
  endfunction
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: UART byte input, program-memory write port and cpu gating of the loader.
interface program_loader_if #(parameter int NB_ADDRESS = 11);
  import program_loader_pkg::*;
  logic                  load;
  byte_t                 rx_data;
  logic                  rx_done;
  logic                  pm_wr_en;
  logic [NB_ADDRESS-1:0] pm_wr_address;
  instr_t                pm_wr_data;
  logic                  cpu_run;
  logic                  busy;
  logic                  error;
  logic [NB_ADDRESS:0]   inst_count;
  modport master (
    input  load, rx_data, rx_done,
    output pm_wr_en, pm_wr_address, pm_wr_data, cpu_run, busy, error, inst_count
  );
  modport slave (
    output load, rx_data, rx_done,
    input  pm_wr_en, pm_wr_address, pm_wr_data, cpu_run, busy, error, inst_count
  );
endinterface

// File: rtl/program_loader_instr_assembler.sv
// program_loader_instr_assembler: holds the high byte and joins it with the incoming low byte.
module program_loader_instr_assembler
  import program_loader_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   latch_high,
  input  byte_t  byte_in,
  output instr_t instr
);
  byte_t high;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) high <= '0;
    else if (latch_high) high <= byte_in;
  assign instr = {high, byte_in};
endmodule

// File: rtl/program_loader.sv
// program_loader: builds instructions from UART bytes, writes them from address 0
// and releases the cpu once a HALT has been stored.
module program_loader #(
  parameter int NB_ADDRESS = 11
) (
  input logic clk,
  input logic rst_n,
  program_loader_if.master bus
);
  import program_loader_pkg::*;
  logic [2:0]            state;
  logic [NB_ADDRESS-1:0] ptr;
  instr_t                instr;
  logic                  latch_high;
  logic                  low_done;
  assign latch_high  = state == ST_WAIT_HIGH && bus.rx_done;
  assign low_done    = state == ST_WAIT_LOW && bus.rx_done;
  assign bus.cpu_run = state == ST_DONE;
  assign bus.busy    = state == ST_WAIT_HIGH || state == ST_WAIT_LOW;
  assign bus.error   = state == ST_ERROR;
  program_loader_instr_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .latch_high(latch_high),
    .byte_in   (bus.rx_data),
    .instr     (instr)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state             <= ST_IDLE;
      ptr               <= '0;
      bus.pm_wr_en      <= 1'b0;
      bus.pm_wr_address <= '0;
      bus.pm_wr_data    <= '0;
      bus.inst_count    <= '0;
    end else begin
      bus.pm_wr_en <= low_done;
      if (low_done) begin
        bus.pm_wr_address <= ptr;
        bus.pm_wr_data    <= instr;
        ptr               <= ptr + 1'b1;
        bus.inst_count    <= bus.inst_count + 1'b1;
      end
      case (state)
        ST_WAIT_HIGH: if (bus.rx_done) state <= ST_WAIT_LOW;
        ST_WAIT_LOW:  if (bus.rx_done) state <= is_halt(instr) ? ST_DONE : &ptr ? ST_ERROR : ST_WAIT_HIGH;
        // IDLE, DONE and ERROR all wait for a load pulse; stray bytes are dropped
        default: if (bus.load) begin
          state          <= ST_WAIT_HIGH;
          ptr            <= '0;
          bus.inst_count <= '0;
        end
      endcase
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream of the BIP cpu. Receives a byte stream from the UART receiver and assembles 16-bit instructions from it.
- Writes the instructions sequentially into program memory starting at address 0.
- Holds the cpu stopped until a HALT instruction has been stored, then asserts a run enable.
- Sits between uart_rx and the program-memory write port and cpu run gating, in the top level next to cpu.

Parameters:
- NB_INSTRUCTION, 16, instruction width; must equal 2*NB_BYTE.
- NB_ADDRESS, 11, program-memory address width.
- NB_OPCODE, 5, opcode field width: the MSBs of the instruction.
- NB_BYTE, 8, UART byte width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_load  in  1  one-cycle pulse that starts a new load session.
- i_rx_data  in  NB_BYTE  received byte; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe from uart_rx.
- o_pm_wr_en  out  1  program-memory write strobe, one cycle wide.
- o_pm_wr_address  out  NB_ADDRESS  write address.
- o_pm_wr_data  out  NB_INSTRUCTION  instruction to write.
- o_cpu_run  out  1  high = cpu may execute; cpu is held in reset while low.
- o_busy  out  1  high while a load session is active.
- o_error  out  1  program overflowed memory without a HALT.
- o_inst_count  out  NB_ADDRESS+1  number of instructions written in the current session.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0; address pointer 0; byte latch 0.
- States: IDLE, WAIT_HIGH, WAIT_LOW, DONE, ERROR.
- IDLE:
  - i_load=1 -> WAIT_HIGH; pointer <= 0; o_inst_count <= 0.
  - i_rx_done is ignored.
- WAIT_HIGH: i_rx_done=1 -> latch i_rx_data as instruction bits [15:8]; go to WAIT_LOW.
- WAIT_LOW: i_rx_done=1 -> instruction = {latched high byte, i_rx_data}.
  - Next cycle: o_pm_wr_en=1 for exactly one cycle, o_pm_wr_address=pointer, o_pm_wr_data=instruction (registered outputs, latency 1 clock from the low-byte strobe).
  - Same edge: pointer and o_inst_count increment.
  - Next state, first matching rule wins:
    - opcode field (instruction[15:11]) == 0 (HALT) -> DONE.
    - pointer == 2^NB_ADDRESS-1 -> ERROR.
    - otherwise -> WAIT_HIGH.
- The HALT instruction itself is always written.
- The pointer never wraps: writing the last address without HALT sends the FSM to ERROR.
- o_pm_wr_address/o_pm_wr_data hold their last values when o_pm_wr_en=0.
- DONE: o_cpu_run=1, o_busy=0. i_load=1 -> o_cpu_run falls on the same edge; go to WAIT_HIGH and clear the counters.
- ERROR: o_error=1, o_cpu_run=0, o_busy=0. i_load=1 -> o_error clears; go to WAIT_HIGH.
- o_busy=1 in WAIT_HIGH and WAIT_LOW; o_cpu_run=1 only in DONE.
- i_load while in WAIT_HIGH or WAIT_LOW is ignored; the session is not restarted.
- i_rx_done in the same cycle as o_pm_wr_en=1 is handled normally as the next high byte; no byte is lost.
- Reset mid-session aborts it: memory contents are left as written, the FSM goes to IDLE, o_cpu_run=0.
- i_load and i_rx_done in the same IDLE cycle: the session starts and the byte is dropped.

Decomposition:
- Package bip_pkg:
  - state encoding constants.
  - OPCODE_HALT = 5'b00000.
  - NB_BYTE.
- Optional sub-module instr_assembler, handling the byte latch and the {high,low} concatenation. The FSM stays in program_loader.
- Total expected size is about 150-200 lines of RTL.

Test Plan:
- Basic load: i_load, then bytes 08 05, 18 03, 00 00 -> writes (0,0x0805), (1,0x1803), (2,0x0000); o_cpu_run=1 one cycle after the last write; o_inst_count=3.
- Timing: low-byte strobe at cycle N -> o_pm_wr_en high only at N+1. Back-to-back rx_done at N+1 is latched as the next high byte.
- Overflow: with NB_ADDRESS=2, send four non-HALT instructions (0x0801 ×4) -> 4 writes, o_error=1, o_cpu_run=0, o_inst_count=4.
- Ignored i_load: an i_load pulse after the 1st byte of 0x0805 -> no restart; 0x0805 is written at address 0.
- Reset mid-session: assert i_reset after one instruction -> all outputs 0 immediately (asynchronous); a new i_load restarts at address 0.
- Reload after DONE: i_load in DONE -> o_cpu_run drops on the next edge; new program written from address 0; o_error stays 0.
